temp_stack: RTL
===============

TEMP_STACK -- requirements
Module: temp_stack

Interface
REQ-001 Parameter: WIDTH, default 16, data width of each temp entry.
REQ-002 Parameter: DEPTH, default 4, number of entries; legal range 2..16.
REQ-003 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  sole clock; all state updates SHALL occur on the falling edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: temp_in  input  WIDTH  data to push.
REQ-007 Port: reg_wr  input  1  active-low push strobe (0 = push).
REQ-008 Port: reg_rd  input  1  active-low pop strobe (0 = pop).
REQ-009 Port: err_clr  input  1  active-high synchronous clear of sticky error flags.
REQ-010 Port: temp_out  output  WIDTH  top-of-stack value; all zeros when empty.
REQ-011 Port: count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-012 Port: empty  output  1  high when count == 0.
REQ-013 Port: full  output  1  high when count == DEPTH.
REQ-014 Port: ovf  output  1  sticky push-while-full flag.
REQ-015 Port: udf  output  1  sticky pop-while-empty flag.

Function
REQ-016 The stack SHALL be LIFO storage of DEPTH x WIDTH registers plus a count register, sampled at each negedge clk.
REQ-017 temp_out, empty and full SHALL be combinational decodes of registered state: valid immediately after the updating edge, with no extra cycle of latency.
REQ-018 Push only (reg_wr=0, reg_rd=1), not full: store temp_in at index count; count +1.
REQ-019 Pop only (reg_wr=1, reg_rd=0), not empty: count -1; the vacated entry is not cleared and SHALL NOT be observable on temp_out.
REQ-020 Push and pop together, not empty: replace the top entry with temp_in; count unchanged.
REQ-021 Push and pop together while empty: treated as a push; count becomes 1; udf not set.
REQ-022 Push while full, no pop: storage and count unchanged; ovf set to 1 at that edge.
REQ-023 Push and pop together while full: replace top per REQ-020; ovf not set.
REQ-024 Pop while empty, no push: count unchanged; udf set to 1 at that edge.
REQ-025 ovf and udf SHALL remain set until err_clr=1 at a negedge or until reset.
REQ-026 If err_clr=1 and a new error occur at the same edge, the new error SHALL win and the flag reads 1 afterwards.
REQ-027 Neither strobe asserted: all state holds.
REQ-028 count SHALL never exceed DEPTH or wrap below 0 under any stimulus.
REQ-029 Strobes are level-sampled: a strobe held low for N falling edges SHALL perform N operations.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, clear count, all entries, ovf and udf to 0; temp_out=0, empty=1, full=0.
REQ-031 While rst_n=0, strobes SHALL be ignored; the first operation takes effect at the first negedge clk with rst_n=1.
REQ-032 Reset asserted in the middle of a sequence of operations SHALL discard all contents; no partial operation survives.

Verification
REQ-033 Reset then push 0x1111, 0x2222, 0x3333 -> temp_out=0x3333, count=3; pop -> temp_out=0x2222, count=2.
REQ-034 DEPTH=4: push 0xA001..0xA004, then push 0xBEEF -> full=1, count=4, temp_out=0xA004, ovf=1; err_clr pulse -> ovf=0.
REQ-035 From empty, pop -> udf=1, count=0, temp_out=0x0000; then push and pop together with 0x5A5A -> count=1, temp_out=0x5A5A, udf stays 1.
REQ-036 Holding 0x1234, 0x5678: push and pop together with 0x9ABC -> count=2, temp_out=0x9ABC; pop -> temp_out=0x1234.
REQ-037 Push 0xFFFF twice, then drop rst_n between clock edges -> count=0, empty=1, temp_out=0x0000 before the next negedge.
REQ-038 Regression at WIDTH=8, DEPTH=2 and WIDTH=32, DEPTH=16: fill to full then drain to empty -> LIFO order preserved; full/empty asserted at the exact boundary edges.

Source files
------------

// File: rtl/temp_stack_if.sv
// temp_stack_if: bus bundle for the temp_stack LIFO.
//   master : drives temp_in, reg_wr (active-low push), reg_rd (active-low pop), err_clr
//   slave  : drives temp_out, count, empty, full, ovf, udf
interface temp_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] temp_in;
  logic             reg_wr;
  logic             reg_rd;
  logic             err_clr;
  logic [WIDTH-1:0] temp_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             udf;

  modport master (
    output temp_in, reg_wr, reg_rd, err_clr,
    input  temp_out, count, empty, full, ovf, udf
  );

  modport slave (
    input  temp_in, reg_wr, reg_rd, err_clr,
    output temp_out, count, empty, full, ovf, udf
  );
endinterface

// File: rtl/temp_stack.sv
// temp_stack: DEPTH x WIDTH LIFO with sticky overflow/underflow flags.
// All state updates on the falling clock edge; reset is asynchronous, active-low.
//   clk   : sole clock (negedge active)
//   rst_n : async active-low reset, clears entries, count and flags
//   bus   : temp_stack_if.slave (push/pop strobes, data in, top/count/status out)

// One storage entry; written only when selected as the write target.
module temp_stack_entry #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)    data_q <= '0;
    else if (we_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

module temp_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  temp_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  // Strobe pair decoded as {push, pop}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  op_e                         op;
  logic [CW-1:0]               count_q, count_d;
  logic                        ovf_q, ovf_d;
  logic                        udf_q, udf_d;
  logic                        ovf_set, udf_set;
  logic                        wr_en;
  logic [CW-1:0]               wr_idx;
  logic [CW-1:0]               top_idx;
  logic                        empty_w, full_w;
  logic [DEPTH-1:0][WIDTH-1:0] ent_q;
  logic [WIDTH-1:0]            top_w;

  assign op      = op_e'({~bus.reg_wr, ~bus.reg_rd});
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign top_idx = count_q - CW'(1);

  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full_w) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = count_q;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty_w) udf_set = 1'b1;
        else         count_d = count_q - CW'(1);
      end
      OP_BOTH: begin
        // On an empty stack the pop half has nothing to remove, so this
        // degenerates to a plain push into slot 0 and is not an underflow.
        wr_en = 1'b1;
        if (empty_w) begin
          wr_idx  = '0;
          count_d = CW'(1);
        end else begin
          wr_idx  = top_idx;
        end
      end
      default: ;
    endcase
  end

  // A new error at the same edge as err_clr takes priority.
  assign ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
  assign udf_d = udf_set | (udf_q & ~bus.err_clr);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    temp_stack_entry #(.WIDTH(WIDTH)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (wr_en && (wr_idx == CW'(i))),
      .d_i   (bus.temp_in),
      .q_o   (ent_q[i])
    );
  end

  // Top-of-stack mux; stale entries above count are never selected and an
  // empty stack reads as zero.
  always_comb begin
    top_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!empty_w && (top_idx == CW'(i))) top_w = ent_q[i];
    end
  end

  assign bus.temp_out = top_w;
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
endmodule
